vga_scan_controller: RTL and testbench
======================================

# vga_scan_controller

Parametrised VGA scan engine for the video output path: generates horizontal/vertical timing for any display mode, reads the frame buffer via a translator-free incremental address, and drives the VGA DAC. Handles arbitrary dot scaling, colour depth and sync polarity. It also handles frame-buffer read latency, keeping sync, blank and colour cycle-aligned. Frame and line strobes are exported for the drawing logic.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths in lines
- HS_POL / VS_POL, 0 / 0, asserted sync level (0 = active-low)
- SCALE_SHIFT, 1, each dot is 2^SCALE_SHIFT × 2^SCALE_SHIFT screen pixels
- COLOUR_CHANNEL_DEPTH, 1, bits per channel, legal range 1..10
- MEM_LATENCY, 1, cycles from memory_address to valid pixel_colour, legal range 0..4
- ADDR_WIDTH, 17, memory_address width

Ports:
- vga_clock  in  1  pixel clock; sole clock
- resetn  in  1  asynchronous, active-low reset
- pixel_colour  in  3*COLOUR_CHANNEL_DEPTH  {R,G,B} from video memory
- memory_address  out  ADDR_WIDTH  dot address, row-major
- VGA_R / VGA_G / VGA_B  out  10 each  DAC channel values
- VGA_HS / VGA_VS  out  1  sync outputs
- VGA_BLANK  out  1  1 = active video
- VGA_SYNC  out  1  constant 1
- VGA_CLK  out  1  equals vga_clock
- frame_start  out  1  one-cycle pulse
- line_start  out  1  one-cycle pulse

## Operation
- Derived values:
  - H_TOTAL = sum of the horizontal parameters.
  - V_TOTAL = sum of the vertical parameters.
  - X_DOTS = H_ACTIVE >> SCALE_SHIFT.
- Counters:
  - xc counts 0..H_TOTAL-1 and wraps to 0.
  - yc increments when xc wraps, and wraps to 0 after V_TOTAL-1.
- Address generation uses no multiplier.
  - row_base resets to 0 when yc wraps to 0.
  - row_base adds X_DOTS when xc wraps and the new yc is a multiple of 2^SCALE_SHIFT and is < V_ACTIVE.
  - In active region: address = row_base + (xc >> SCALE_SHIFT).
  - Outside the active region the address is 0.
- Sync and blank for position (xc, yc):
  - HS asserted when H_ACTIVE+H_FRONT <= xc < H_ACTIVE+H_FRONT+H_SYNC.
  - VS asserted when V_ACTIVE+V_FRONT <= yc < V_ACTIVE+V_FRONT+V_SYNC.
  - BLANK = (xc < H_ACTIVE) && (yc < V_ACTIVE).
- Colour expansion:
  - Bit mapping: VGA_R[9-i] = R[D-1-(i mod D)] for i = 0..9; same for G and B.
  - When D does not divide 10, the low bits carry the MSBs of the repeated pattern.
  - Output is 0 whenever the aligned BLANK is 0.
- Strobes:
  - frame_start fires for position (0, 0).
  - line_start fires for xc = 0 with yc < V_ACTIVE.
  - Both strobes are aligned with the same delayed pipeline as VGA_BLANK.

## Timing
- PIPE = MEM_LATENCY + 2.
- For counter position (xc, yc) in cycle t:
  - memory_address is registered and valid at t+1.
  - pixel_colour is sampled at t+1+MEM_LATENCY.
  - VGA_R/G/B, VGA_HS, VGA_VS, VGA_BLANK, frame_start and line_start all reflect (xc, yc) at t+PIPE.
- Every RGB/sync/blank/strobe output is a register; there are no combinational paths from pixel_colour.
- Reset values:
  - xc = yc = row_base = 0; memory_address = 0.
  - RGB = 0; VGA_BLANK = 0; frame_start = line_start = 0.
  - VGA_HS = ~HS_POL and VGA_VS = ~VS_POL (deasserted).
  - All delay-line stages are cleared.
- On reset release: counting starts at (0, 0); the first frame_start appears PIPE cycles after the first active edge.
- Reset mid-frame: all state returns to reset values immediately (asynchronously). No partial line or pulse resumes.
- Simultaneous xc and yc wrap: row_base clears; the wrap takes priority over the X_DOTS add.

## Test plan
- Reset: hold resetn low.
  - Outputs: RGB = 0, BLANK = 0, HS = VS = 1 (defaults), address = 0.
  - Release: first frame_start after exactly 3 cycles (MEM_LATENCY = 1).
- Line timing (defaults):
  - VGA_HS low for exactly 96 cycles, starting 656+3 cycles after line_start position 0.
  - Line period 800 cycles; frame_start period 420000 cycles.
- Address sequence (SCALE_SHIFT = 1):
  - Line 0 addresses 0,0,1,1,…,319,319; line 1 repeats 0..319; line 2 starts at 320.
  - Last active dot address is 76799; address is 0 during blanking.
- Latency alignment: MEM_LATENCY = 3, memory model returns address low bits.
  - VGA_R/G/B match the expected dot at each active pixel.
  - RGB = 0 in every blank cycle; BLANK-to-RGB skew is 0.
- Colour expansion: COLOUR_CHANNEL_DEPTH = 3, R = 3'b101 -> VGA_R = 10'b1011011011.
  - With D = 1: R = 1 -> VGA_R = 10'h3FF.
- Polarity and mid-frame reset: HS_POL = 1 -> HS high during sync only.
  - Assert resetn at yc = 200 -> outputs reach reset values in the same cycle.
  - Frame restarts at (0, 0) with address 0.

Source files
------------

// File: rtl/vga_scan_controller.sv
// vga_scan_controller
//   Parametrised VGA scan engine. Generates horizontal/vertical timing, walks the
//   frame buffer with an incremental row-major dot address, expands the returned
//   colour to the 10-bit DAC channels and keeps sync/blank/strobes cycle-aligned
//   with the colour across the frame-buffer read latency.
//
// Ports
//   vga_clock       in   pixel clock (sole clock)
//   resetn          in   asynchronous active-low reset
//   pixel_colour    in   {R,G,B} from video memory, COLOUR_CHANNEL_DEPTH bits each
//   memory_address  out  registered dot address, row-major
//   VGA_R/G/B       out  10-bit DAC channel values (0 outside active video)
//   VGA_HS/VGA_VS   out  sync outputs, asserted level HS_POL/VS_POL
//   VGA_BLANK       out  1 = active video
//   VGA_SYNC        out  constant 1
//   VGA_CLK         out  copy of vga_clock
//   frame_start     out  one-cycle pulse for position (0,0)
//   line_start      out  one-cycle pulse at xc = 0 of every active line
module vga_scan_controller #(
  parameter int H_ACTIVE             = 640,
  parameter int H_FRONT              = 16,
  parameter int H_SYNC               = 96,
  parameter int H_BACK               = 48,
  parameter int V_ACTIVE             = 480,
  parameter int V_FRONT              = 10,
  parameter int V_SYNC               = 2,
  parameter int V_BACK               = 33,
  parameter bit HS_POL               = 1'b0,
  parameter bit VS_POL               = 1'b0,
  parameter int SCALE_SHIFT          = 1,
  parameter int COLOUR_CHANNEL_DEPTH = 1,
  parameter int MEM_LATENCY          = 1,
  parameter int ADDR_WIDTH           = 17
) (
  input  logic                                vga_clock,
  input  logic                                resetn,
  input  logic [3*COLOUR_CHANNEL_DEPTH-1:0]   pixel_colour,
  output logic [ADDR_WIDTH-1:0]               memory_address,
  output logic [9:0]                          VGA_R,
  output logic [9:0]                          VGA_G,
  output logic [9:0]                          VGA_B,
  output logic                                VGA_HS,
  output logic                                VGA_VS,
  output logic                                VGA_BLANK,
  output logic                                VGA_SYNC,
  output logic                                VGA_CLK,
  output logic                                frame_start,
  output logic                                line_start
);

  localparam int D        = COLOUR_CHANNEL_DEPTH;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int X_DOTS   = H_ACTIVE >> SCALE_SHIFT;
  localparam int XW       = $clog2(H_TOTAL);
  localparam int YW       = $clog2(V_TOTAL);
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DOT_MASK = (1 << SCALE_SHIFT) - 1;

  // Sync flags travel as "asserted" booleans so cleared stages mean deasserted;
  // polarity is applied only at the output register.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic fs;
    logic ls;
  } ctl_t;

  // Repeat the channel MSB-first across 10 bits; when D does not divide 10 the
  // low bits receive the leading bits of the next repetition.
  function automatic logic [9:0] expand(input logic [D-1:0] ch);
    logic [9:0] o;
    o = '0;
    for (int i = 0; i < 10; i++) o[9-i] = ch[D-1-(i % D)];
    return o;
  endfunction

  logic [XW-1:0]         xc;
  logic [YW-1:0]         yc;
  logic [YW-1:0]         yc_inc;
  logic [31:0]           xw;
  logic [31:0]           yw;
  logic                  x_last;
  logic                  y_last;
  logic [ADDR_WIDTH-1:0] row_base;
  ctl_t                  ctl_now;
  ctl_t                  ctl_p [0:MEM_LATENCY];
  logic [D-1:0]          r_in;
  logic [D-1:0]          g_in;
  logic [D-1:0]          b_in;

  assign xw     = 32'(xc);
  assign yw     = 32'(yc);
  assign x_last = (xw == 32'(H_TOTAL - 1));
  assign y_last = (yw == 32'(V_TOTAL - 1));
  assign yc_inc = yc + YW'(1);

  assign r_in = pixel_colour[3*D-1:2*D];
  assign g_in = pixel_colour[2*D-1:D];
  assign b_in = pixel_colour[D-1:0];

  assign VGA_SYNC = 1'b1;
  assign VGA_CLK  = vga_clock;

  // Scan counters and row base (row_base tracks (yc >> SCALE_SHIFT) * X_DOTS
  // incrementally; the frame wrap wins over the per-row add)
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      xc       <= '0;
      yc       <= '0;
      row_base <= '0;
    end else if (x_last) begin
      xc <= '0;
      if (y_last) begin
        yc       <= '0;
        row_base <= '0;
      end else begin
        yc <= yc_inc;
        if (((32'(yc_inc) & 32'(DOT_MASK)) == 32'd0) && (32'(yc_inc) < 32'(V_ACTIVE)))
          row_base <= row_base + ADDR_WIDTH'(X_DOTS);
      end
    end else begin
      xc <= xc + XW'(1);
    end
  end

  always_comb begin
    ctl_now       = '0;
    ctl_now.blank = (xw < 32'(H_ACTIVE)) && (yw < 32'(V_ACTIVE));
    ctl_now.hs    = (xw >= 32'(HS_START)) && (xw < 32'(HS_END));
    ctl_now.vs    = (yw >= 32'(VS_START)) && (yw < 32'(VS_END));
    ctl_now.fs    = (xw == 32'd0) && (yw == 32'd0);
    ctl_now.ls    = (xw == 32'd0) && (yw < 32'(V_ACTIVE));
  end

  // Stage p0: address issue and start of the control delay line
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      memory_address <= '0;
    end else begin
      memory_address <= ctl_now.blank ? row_base + ADDR_WIDTH'(xc >> SCALE_SHIFT) : '0;
    end
  end

  // Stages p0..pMEM_LATENCY: control waits for the memory read to return
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i <= MEM_LATENCY; i++) ctl_p[i] <= '0;
    end else begin
      ctl_p[0] <= ctl_now;
      for (int i = 1; i <= MEM_LATENCY; i++) ctl_p[i] <= ctl_p[i-1];
    end
  end

  // Output stage: colour sampled together with its aligned control
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_BLANK   <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      VGA_R       <= ctl_p[MEM_LATENCY].blank ? expand(r_in) : '0;
      VGA_G       <= ctl_p[MEM_LATENCY].blank ? expand(g_in) : '0;
      VGA_B       <= ctl_p[MEM_LATENCY].blank ? expand(b_in) : '0;
      VGA_HS      <= ctl_p[MEM_LATENCY].hs ? HS_POL : ~HS_POL;
      VGA_VS      <= ctl_p[MEM_LATENCY].vs ? VS_POL : ~VS_POL;
      VGA_BLANK   <= ctl_p[MEM_LATENCY].blank;
      frame_start <= ctl_p[MEM_LATENCY].fs;
      line_start  <= ctl_p[MEM_LATENCY].ls;
    end
  end

endmodule

// File: tb/tb_vga_scan_controller.sv
// tb_vga_scan_controller
//   Small display mode (16x8 visible, 24x12 total), 2x dot scaling, 3-bit
//   channels, memory latency 3, active-high HS and active-low VS. A random frame
//   buffer feeds a latency-3 memory model; every output is compared each cycle
//   against positions and addresses computed arithmetically from the cycle
//   count since reset release.
module tb_vga_scan_controller;

  localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VSW = 2, VB = 1;
  localparam bit HS_POL = 1'b1;
  localparam bit VS_POL = 1'b0;
  localparam int S  = 1;
  localparam int D  = 3;
  localparam int ML = 3;
  localparam int AW = 8;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int XD = HA >> S;
  localparam int PIPE = ML + 2;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [3*D-1:0] pixel_colour;
  logic [AW-1:0] memory_address;
  logic [9:0]    vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs, vga_blank, vga_sync, vga_clk;
  logic          frame_start, line_start;

  int errors = 0;
  int checks = 0;

  logic [3*D-1:0] mem [0:255];
  logic [3*D-1:0] mq  [0:ML-1];

  always #5 clk = ~clk;

  vga_scan_controller #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .SCALE_SHIFT(S),
    .COLOUR_CHANNEL_DEPTH(D), .MEM_LATENCY(ML), .ADDR_WIDTH(AW)
  ) dut (
    .vga_clock(clk),
    .resetn(resetn),
    .pixel_colour(pixel_colour),
    .memory_address(memory_address),
    .VGA_R(vga_r),
    .VGA_G(vga_g),
    .VGA_B(vga_b),
    .VGA_HS(vga_hs),
    .VGA_VS(vga_vs),
    .VGA_BLANK(vga_blank),
    .VGA_SYNC(vga_sync),
    .VGA_CLK(vga_clk),
    .frame_start(frame_start),
    .line_start(line_start)
  );

  // Frame-buffer model: data for an address appears ML cycles after it is presented
  always @(posedge clk) begin
    mq[0] <= mem[memory_address];
    for (int i = 1; i < ML; i++) mq[i] <= mq[i-1];
  end
  assign pixel_colour = mq[ML-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Channel replicated MSB-first, top ten bits kept
  function automatic logic [9:0] expand_ref(input logic [2:0] c);
    logic [11:0] rep;
    rep = {c, c, c, c};
    return rep[11:2];
  endfunction

  function automatic int dot_addr(input int x, input int y);
    if (x < HA && y < VA) return (y >> S) * XD + (x >> S);
    return 0;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_addr"},  32'(memory_address), 32'd0);
    check({tag, "_r"},     32'(vga_r), 32'd0);
    check({tag, "_g"},     32'(vga_g), 32'd0);
    check({tag, "_b"},     32'(vga_b), 32'd0);
    check({tag, "_blank"}, 32'(vga_blank), 32'd0);
    check({tag, "_hs"},    32'(vga_hs), 32'(!HS_POL));
    check({tag, "_vs"},    32'(vga_vs), 32'(!VS_POL));
    check({tag, "_fs"},    32'(frame_start), 32'd0);
    check({tag, "_ls"},    32'(line_start), 32'd0);
    check({tag, "_sync"},  32'(vga_sync), 32'd1);
  endtask

  // k = number of active edges since reset release
  task automatic check_cycle(input int k);
    int p, x, y, a;
    logic act;
    logic [3*D-1:0] col;
    logic [9:0] er, eg, eb;
    logic ehs, evs, efs, els;
    if (k == 0) a = 0;
    else a = dot_addr((k - 1) % HT, ((k - 1) / HT) % VT);
    check($sformatf("addr@%0d", k), 32'(memory_address), 32'(a));

    p = k - PIPE;
    if (p < 0) begin
      act = 1'b0; er = '0; eg = '0; eb = '0;
      ehs = !HS_POL; evs = !VS_POL; efs = 1'b0; els = 1'b0;
    end else begin
      x   = p % HT;
      y   = (p / HT) % VT;
      act = (x < HA) && (y < VA);
      col = mem[8'(dot_addr(x, y))];
      er  = act ? expand_ref(col[8:6]) : 10'd0;
      eg  = act ? expand_ref(col[5:3]) : 10'd0;
      eb  = act ? expand_ref(col[2:0]) : 10'd0;
      ehs = (x >= HA + HF && x < HA + HF + HSW) ? HS_POL : !HS_POL;
      evs = (y >= VA + VF && y < VA + VF + VSW) ? VS_POL : !VS_POL;
      efs = (x == 0) && (y == 0);
      els = (x == 0) && (y < VA);
    end
    check($sformatf("r@%0d", k),     32'(vga_r), 32'(er));
    check($sformatf("g@%0d", k),     32'(vga_g), 32'(eg));
    check($sformatf("b@%0d", k),     32'(vga_b), 32'(eb));
    check($sformatf("hs@%0d", k),    32'(vga_hs), 32'(ehs));
    check($sformatf("vs@%0d", k),    32'(vga_vs), 32'(evs));
    check($sformatf("blank@%0d", k), 32'(vga_blank), 32'(act));
    check($sformatf("fs@%0d", k),    32'(frame_start), 32'(efs));
    check($sformatf("ls@%0d", k),    32'(line_start), 32'(els));
  endtask

  task automatic run_from_release(input int n);
    @(negedge clk);
    resetn = 1'b1;
    #1 check_cycle(0);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1 check_cycle(k);
    end
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock
  task automatic reset_mid_frame(input int hold);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1 check_reset("async_rst");
    repeat (hold) @(posedge clk);
    #1 check_reset("rst_hold");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 9'($urandom);
    mem[0] = 9'b101_000_111;

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("rst");

    run_from_release(2 * FRAME + 40);

    // Stop around line 5..6 of the next frame (mid-frame reset)
    reset_mid_frame(2);
    run_from_release(FRAME + 5 * HT + int'($urandom_range(0, HT - 1)));

    reset_mid_frame(1 + int'($urandom_range(0, 3)));
    run_from_release(FRAME + int'($urandom_range(10, FRAME - 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
